// File: rtl/port_qos_scheduler.sv
// port_qos_scheduler
// Per-output-port packet scheduler. Counts complete packets buffered per
// priority, picks the next queue to drain (strict priority or weighted
// round-robin), and walks the shared-cache reader through one
// request / acknowledge / done handshake per packet.
module port_qos_scheduler #(
   parameter int PRIORITY       = 8,
   parameter int WIDTH_PRIORITY = $clog2(PRIORITY),
   parameter int CNT_WIDTH      = 8,
   parameter int WEIGHT_WIDTH   = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             enq_vld,
   input  logic [WIDTH_PRIORITY-1:0]        enq_priority,
   input  logic                             qos_controll,
   input  logic [PRIORITY*WEIGHT_WIDTH-1:0] weight,
   input  logic                             ready,
   output logic                             sched_vld,
   output logic [WIDTH_PRIORITY-1:0]        sched_priority,
   input  logic                             sched_ack,
   input  logic                             pkt_done,
   output logic                             busy,
   output logic                             queue_empty,
   output logic                             error
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_XFER = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [CNT_WIDTH-1:0]      cnt_q [PRIORITY];
   logic [WIDTH_PRIORITY-1:0] ptr_q, ptr_d;
   logic [WEIGHT_WIDTH-1:0]   credit_q, credit_d;
   logic [WIDTH_PRIORITY-1:0] sel_q, sel_d;
   logic                      error_q;

   logic [PRIORITY-1:0]       nz;
   logic                      any_nz;
   logic [WIDTH_PRIORITY-1:0] sp_sel;
   logic [WIDTH_PRIORITY-1:0] wrr_sel;
   logic                      wrr_found;
   logic [WEIGHT_WIDTH-1:0]   wrr_weight;
   logic [WEIGHT_WIDTH-1:0]   wrr_credit;
   logic                      deq;
   logic [PRIORITY-1:0]       ovf;
   int                        idx;

   // Which queues hold at least one complete packet.
   always_comb begin
      for (int p = 0; p < PRIORITY; p++) begin
         nz[p] = |cnt_q[p];
      end
      any_nz = |nz;
   end

   // Strict priority: the highest nonzero index wins (later iterations override).
   always_comb begin
      sp_sel = '0;
      for (int p = 0; p < PRIORITY; p++) begin
         if (nz[p]) begin
            sp_sel = WIDTH_PRIORITY'(p);
         end
      end
   end

   // WRR search: walk downward from ptr-1 with wrap, ending at ptr itself.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      wrr_sel   = ptr_q;
      wrr_found = 1'b0;
      idx       = 0;
      for (int k = 1; k <= PRIORITY; k++) begin
         idx = (int'(ptr_q) - k + PRIORITY) % PRIORITY;
         if (!wrr_found && nz[idx]) begin
            wrr_found = 1'b1;
            wrr_sel   = WIDTH_PRIORITY'(idx);
         end
      end
      wrr_weight = weight[wrr_sel*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      // A weight of zero behaves like one: the new turn carries no extra credit.
      wrr_credit = (wrr_weight == '0) ? '0 : wrr_weight - 1'b1;
   end

   // Next-state, selection and WRR bookkeeping for the handshake FSM.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      credit_d = credit_q;
      sel_d    = sel_q;
      unique case (state_q)
         ST_IDLE: begin
            if (ready && any_nz) begin
               state_d = ST_REQ;
               if (!qos_controll) begin
                  sel_d = sp_sel;
               end else if (nz[ptr_q] && (credit_q != '0)) begin
                  sel_d    = ptr_q;
                  credit_d = credit_q - 1'b1;
               end else begin
                  sel_d    = wrr_sel;
                  ptr_d    = wrr_sel;
                  credit_d = wrr_credit;
               end
            end
         end
         ST_REQ: begin
            // The request is held until acknowledged, regardless of ready.
            if (sched_ack) begin
               state_d = ST_XFER;
            end
         end
         ST_XFER: begin
            if (pkt_done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign deq = (state_q == ST_REQ) && sched_ack;

   // State, selection and WRR pointer/credit registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         ptr_q    <= WIDTH_PRIORITY'(PRIORITY - 1);
         credit_q <= '0;
         sel_q    <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values and simulation matches hardware.
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         credit_q <= credit_d;
         sel_q    <= sel_d;
      end
   end

   // Overflow detection: increment on an all-ones counter without a matching decrement.
   always_comb begin
      for (int p = 0; p < PRIORITY; p++) begin
         ovf[p] = enq_vld && (enq_priority == WIDTH_PRIORITY'(p))
                  && !(deq && (sel_q == WIDTH_PRIORITY'(p)))
                  && (&cnt_q[p]);
      end
   end

   // Per-priority pending-packet counters; a same-cycle enqueue and dequeue cancel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: this counter array is reset explicitly; pending counts must
         // read zero after reset, so it cannot be left as an uninitialised RAM.
         for (int p = 0; p < PRIORITY; p++) begin
            cnt_q[p] <= '0;
         end
      end else begin
         for (int p = 0; p < PRIORITY; p++) begin
            if (enq_vld && (enq_priority == WIDTH_PRIORITY'(p))
                && !(deq && (sel_q == WIDTH_PRIORITY'(p)))) begin
               if (!(&cnt_q[p])) begin
                  cnt_q[p] <= cnt_q[p] + 1'b1;
               end
            end else if (deq && (sel_q == WIDTH_PRIORITY'(p))
                         && !(enq_vld && (enq_priority == WIDTH_PRIORITY'(p)))) begin
               cnt_q[p] <= cnt_q[p] - 1'b1;
            end
         end
      end
   end

   // One-cycle error pulse following an overflowing enqueue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         error_q <= 1'b0;
      end else begin
         error_q <= |ovf;
      end
   end

   assign sched_vld      = (state_q == ST_REQ);
   assign sched_priority = sel_q;
   assign busy           = (state_q != ST_IDLE);
   assign queue_empty    = !any_nz;
   assign error          = error_q;

endmodule

// File: tb/tb_port_qos_scheduler.sv
// tb_port_qos_scheduler
// Directed bench: stimulus pushes expected grant priorities into a queue;
// an independent monitor pops and compares at each accepted request.
// A second instance with 2-bit counters exercises overflow.
module tb_port_qos_scheduler;

   localparam int P  = 8;
   localparam int WP = 3;
   localparam int WW = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            enq_vld = 1'b0;
   logic [WP-1:0]   enq_priority = '0;
   logic            qos_controll = 1'b0;
   logic [P*WW-1:0] weight = '0;
   logic            ready = 1'b0;
   logic            sched_vld;
   logic [WP-1:0]   sched_priority;
   logic            sched_ack = 1'b0;
   logic            pkt_done = 1'b0;
   logic            busy;
   logic            queue_empty;
   logic            error;

   logic            o_enq_vld = 1'b0;
   logic            o_ready = 1'b0;
   logic            o_vld;
   logic [WP-1:0]   o_prio;
   logic            o_ack = 1'b0;
   logic            o_done = 1'b0;
   logic            o_busy;
   logic            o_empty;
   logic            o_err;

   int              n_checks = 0;
   int              n_pass = 0;
   int              grant_idx = 0;
   int              main_err_pulses = 0;
   int              o_err_pulses = 0;
   int              o_grants4 = 0;
   logic [WP-1:0]   exp_q [$];

   port_qos_scheduler #(.PRIORITY(P), .CNT_WIDTH(8), .WEIGHT_WIDTH(WW)) dut (
      .clk(clk), .rst_n(rst_n), .enq_vld(enq_vld), .enq_priority(enq_priority),
      .qos_controll(qos_controll), .weight(weight), .ready(ready),
      .sched_vld(sched_vld), .sched_priority(sched_priority), .sched_ack(sched_ack),
      .pkt_done(pkt_done), .busy(busy), .queue_empty(queue_empty), .error(error)
   );

   port_qos_scheduler #(.PRIORITY(P), .CNT_WIDTH(2), .WEIGHT_WIDTH(WW)) dut_ovf (
      .clk(clk), .rst_n(rst_n), .enq_vld(o_enq_vld), .enq_priority(3'd4),
      .qos_controll(1'b0), .weight(weight), .ready(o_ready),
      .sched_vld(o_vld), .sched_priority(o_prio), .sched_ack(o_ack),
      .pkt_done(o_done), .busy(o_busy), .queue_empty(o_empty), .error(o_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Monitor: every accepted request is compared against the scoreboard.
   always @(negedge clk) begin
      if (rst_n && sched_vld === 1'b1 && sched_ack === 1'b1) begin
         if (exp_q.size() == 0) begin
            check($sformatf("unexpected grant %0d", grant_idx), 32'(sched_priority), 32'hFFFF);
         end else begin
            check($sformatf("grant %0d", grant_idx), 32'(sched_priority), 32'(exp_q.pop_front()));
         end
         grant_idx++;
      end
      if (error === 1'b1) main_err_pulses++;
      if (o_err === 1'b1) o_err_pulses++;
      if (o_vld === 1'b1 && o_ack === 1'b1 && o_prio == 3'd4) o_grants4++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic enq_one(input logic [WP-1:0] p);
      @(posedge clk); #1;
      enq_vld = 1'b1;
      enq_priority = p;
   endtask

   task automatic enq_stop();
      @(posedge clk); #1;
      enq_vld = 1'b0;
   endtask

   task automatic wait_vld(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (sched_vld === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("wait sched_vld timeout", 0, 1);
   endtask

   // One full handshake; optionally holds the ack while checking stability,
   // and optionally enqueues alongside the ack.
   task automatic serve(input int ack_wait, input bit hold_chk,
                        input bit enq_at_ack, input logic [WP-1:0] enq_p);
      bit ok;
      logic [WP-1:0] p0;
      wait_vld(ok);
      if (!ok) return;
      p0 = sched_priority;
      if (hold_chk) ready = 1'b0;
      for (int i = 0; i < ack_wait; i++) begin
         @(negedge clk);
         if (hold_chk) begin
            check("hold sched_vld", 32'(sched_vld), 1);
            check("hold sched_priority", 32'(sched_priority), 32'(p0));
            check("hold queue_empty", 32'(queue_empty), 0);
         end
      end
      @(posedge clk); #1;
      sched_ack = 1'b1;
      if (enq_at_ack) begin
         enq_vld = 1'b1;
         enq_priority = enq_p;
      end
      @(posedge clk); #1;
      sched_ack = 1'b0;
      enq_vld = 1'b0;
      repeat (3) @(posedge clk);
      #1 pkt_done = 1'b1;
      @(posedge clk); #1;
      pkt_done = 1'b0;
   endtask

   initial begin
      bit ok;
      bit saw_vld;
      weight = '0;
      weight[7*WW +: WW] = 4'd3;
      weight[0*WW +: WW] = 4'd1;

      // Reset state
      #12;
      check("reset sched_vld", 32'(sched_vld), 0);
      check("reset sched_priority", 32'(sched_priority), 0);
      check("reset busy", 32'(busy), 0);
      check("reset queue_empty", 32'(queue_empty), 1);
      check("reset error", 32'(error), 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Overflow on a 2-bit counter instance: 4 enqueues at p4, only 3 retained.
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1 o_enq_vld = 1'b1;
      end
      @(posedge clk); #1 o_enq_vld = 1'b0;
      @(negedge clk);
      check("ovf error pulse", 32'(o_err), 1);
      @(negedge clk);
      check("ovf error drop", 32'(o_err), 0);
      o_ready = 1'b1;
      for (int g = 0; g < 5; g++) begin
         ok = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_vld === 1'b1) begin ok = 1'b1; break; end
         end
         if (!ok) break;
         @(posedge clk); #1 o_ack = 1'b1;
         @(posedge clk); #1 o_ack = 1'b0;
         @(posedge clk); #1 o_done = 1'b1;
         @(posedge clk); #1 o_done = 1'b0;
      end
      o_ready = 1'b0;
      check("ovf grants p4", 32'(o_grants4), 3);
      check("ovf error pulses", 32'(o_err_pulses), 1);
      check("ovf queue_empty", 32'(o_empty), 1);

      // Strict priority: enqueue 1,5,3 with ready low, then release.
      qos_controll = 1'b0;
      ready = 1'b0;
      enq_one(3'd1);
      enq_one(3'd5);
      enq_one(3'd3);
      enq_stop();
      exp_q.push_back(3'd5);
      exp_q.push_back(3'd3);
      exp_q.push_back(3'd1);
      ready = 1'b1;
      for (int i = 0; i < 3; i++) serve(0, 1'b0, 1'b0, '0);
      check("strict queue_empty", 32'(queue_empty), 1);

      // Handshake hold: ack delayed 10 cycles with ready dropped meanwhile.
      ready = 1'b0;
      enq_one(3'd6);
      enq_stop();
      exp_q.push_back(3'd6);
      ready = 1'b1;
      serve(10, 1'b1, 1'b0, '0);
      check("hold queue_empty after ack", 32'(queue_empty), 1);
      check("hold sched_vld after ack", 32'(sched_vld), 0);

      // Simultaneous enqueue and dequeue on p2.
      ready = 1'b0;
      enq_one(3'd2);
      enq_stop();
      exp_q.push_back(3'd2);
      exp_q.push_back(3'd2);
      ready = 1'b1;
      serve(0, 1'b0, 1'b1, 3'd2);
      check("simul queue_empty", 32'(queue_empty), 0);
      check("simul error", 32'(error), 0);
      serve(0, 1'b0, 1'b0, '0);
      check("simul drained", 32'(queue_empty), 1);

      // WRR: one p0 packet first moves ptr from 7 to 0 (credit 0), so the
      // weighted run below starts its search at p7.
      qos_controll = 1'b1;
      ready = 1'b0;
      enq_one(3'd0);
      enq_stop();
      exp_q.push_back(3'd0);
      ready = 1'b1;
      serve(0, 1'b0, 1'b0, '0);
      ready = 1'b0;
      for (int i = 0; i < 6; i++) enq_one(3'd7);
      for (int i = 0; i < 6; i++) enq_one(3'd0);
      enq_stop();
      begin
         logic [WP-1:0] wrr_exp [12] = '{3'd7, 3'd7, 3'd7, 3'd0, 3'd7, 3'd7,
                                         3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
         foreach (wrr_exp[i]) exp_q.push_back(wrr_exp[i]);
      end
      ready = 1'b1;
      for (int i = 0; i < 12; i++) serve(0, 1'b0, 1'b0, '0);
      check("wrr queue_empty", 32'(queue_empty), 1);

      // Reset mid-XFER with 2 packets pending.
      qos_controll = 1'b0;
      ready = 1'b0;
      for (int i = 0; i < 3; i++) enq_one(3'd3);
      enq_stop();
      exp_q.push_back(3'd3);
      ready = 1'b1;
      wait_vld(ok);
      @(posedge clk); #1 sched_ack = 1'b1;
      @(posedge clk); #1 sched_ack = 1'b0;
      check("xfer busy", 32'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid reset sched_vld", 32'(sched_vld), 0);
      check("mid reset busy", 32'(busy), 0);
      check("mid reset queue_empty", 32'(queue_empty), 1);
      check("mid reset sched_priority", 32'(sched_priority), 0);
      check("mid reset error", 32'(error), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      saw_vld = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (sched_vld !== 1'b0) saw_vld = 1'b1;
      end
      check("no request after reset", 32'(saw_vld), 0);
      ready = 1'b0;
      enq_one(3'd1);
      enq_stop();
      exp_q.push_back(3'd1);
      ready = 1'b1;
      serve(0, 1'b0, 1'b0, '0);

      repeat (3) @(posedge clk);
      check("scoreboard drained", 32'(exp_q.size()), 0);
      check("main error pulses", 32'(main_err_pulses), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
